// File: rtl/sm2201_isa_pkg.sv
// Shared definitions for the sm2201 ISA front end: bus widths, default window
// base, the data returned on a read timeout and the cycle decoder state encoding.
package sm2201_isa_pkg;

  localparam int ISA_ADDR_W = 10;
  localparam logic [ISA_ADDR_W-1:0] DEFAULT_BASE_ADDR = 10'h100;
  localparam logic [7:0] TIMEOUT_READ_DATA = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_WAIT  = 3'd1,
    ST_RD_DRIVE = 3'd2,
    ST_WR_WAIT  = 3'd3,
    ST_RELEASE  = 3'd4
  } isa_state_t;

endpackage

// File: rtl/isa_strobe_sync.sv
// Multi-flop synchroniser for an active-low asynchronous ISA strobe.
// Resets to 1 so that a strobe is never seen as active straight out of reset.
module isa_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] stage_reg;
  logic [SYNC_STAGES-1:0] stage_next;

  assign stage_next[0] = async_in;

  genvar gi;
  generate
    for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_stage
      assign stage_next[gi] = stage_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stage_reg <= '1;
    end else begin
      stage_reg <= stage_next;
    end
  end

  assign sync_out = stage_reg[SYNC_STAGES-1];

endmodule

// File: rtl/isa_bus_cycle_decoder.sv
// ISA I/O cycle front end: latches and decodes the slot address, synchronises
// IOR/IOW and turns each addressed strobe into one backend register request.
module isa_bus_cycle_decoder
  import sm2201_isa_pkg::*;
#(
  parameter logic [ISA_ADDR_W-1:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
  parameter int                    ADDR_BITS    = 3,
  parameter int                    SYNC_STAGES  = 2,
  parameter int                    WAIT_TIMEOUT = 16
) (
  input  logic                  isa_clk,
  input  logic                  isa_reset,
  input  logic                  isa_ior,
  input  logic                  isa_iow,
  input  logic                  isa_ale,
  input  logic                  isa_aen,
  input  logic [ISA_ADDR_W-1:0] isa_addr,
  input  logic [7:0]            isa_data_in,
  output logic [7:0]            isa_data_out,
  output logic                  isa_data_oe,
  output logic                  isa_chrdy,
  output logic [ADDR_BITS-1:0]  reg_addr,
  output logic                  reg_rd,
  output logic                  reg_wr,
  output logic [7:0]            reg_wdata,
  input  logic [7:0]            reg_rdata,
  input  logic                  reg_ack,
  output logic                  err_timeout,
  output logic                  err_protocol
);

  localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);

  logic ior_s;
  logic iow_s;

  isa_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) ior_sync (
    .clk      (isa_clk),
    .reset_n  (isa_reset),
    .async_in (isa_ior),
    .sync_out (ior_s)
  );

  isa_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) iow_sync (
    .clk      (isa_clk),
    .reset_n  (isa_reset),
    .async_in (isa_iow),
    .sync_out (iow_s)
  );

  isa_state_t             state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [ISA_ADDR_W-1:0]  addr_hold_reg;
  logic [ISA_ADDR_W-1:0]  addr_latched;
  logic [ISA_ADDR_W-1:0]  offset;
  logic                   hit;
  logic [7:0]             data_out_reg, data_out_next;
  logic                   oe_reg, oe_next;
  logic                   chrdy_reg, chrdy_next;
  logic [ADDR_BITS-1:0]   reg_addr_reg, reg_addr_next;
  logic                   rd_reg, rd_next;
  logic                   wr_reg, wr_next;
  logic [7:0]             wdata_reg, wdata_next;
  logic                   err_to_reg, err_to_next;
  logic                   err_pr_reg, err_pr_next;

  // Register-based transparent latch: follows the pins while ALE is high.
  assign addr_latched = isa_ale ? isa_addr : addr_hold_reg;
  assign offset       = addr_latched - BASE_ADDR;
  assign hit          = (addr_latched >= BASE_ADDR) && ((offset >> ADDR_BITS) == '0) && !isa_aen;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    data_out_next = data_out_reg;
    oe_next       = oe_reg;
    chrdy_next    = chrdy_reg;
    reg_addr_next = reg_addr_reg;
    rd_next       = 1'b0;
    wr_next       = 1'b0;
    wdata_next    = wdata_reg;
    err_to_next   = 1'b0;
    err_pr_next   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (!ior_s && !iow_s) begin
          err_pr_next = 1'b1;
          state_next  = ST_RELEASE;
        end else if (!ior_s || !iow_s) begin
          // Unaddressed cycles leave every output untouched.
          if (hit) begin
            reg_addr_next = offset[ADDR_BITS-1:0];
            chrdy_next    = 1'b0;
            cnt_next      = '0;
            if (!ior_s) begin
              rd_next    = 1'b1;
              state_next = ST_RD_WAIT;
            end else begin
              wr_next    = 1'b1;
              wdata_next = isa_data_in;
              state_next = ST_WR_WAIT;
            end
          end else begin
            state_next = ST_RELEASE;
          end
        end
      end

      ST_RD_WAIT: begin
        cnt_next = cnt_reg + CNT_W'(1);
        // An ack arriving alongside the request strobe is not a real completion.
        if (reg_ack && !rd_reg) begin
          data_out_next = reg_rdata;
          oe_next       = 1'b1;
          chrdy_next    = 1'b1;
          state_next    = ST_RD_DRIVE;
        end else if (cnt_reg == CNT_LAST) begin
          err_to_next   = 1'b1;
          data_out_next = TIMEOUT_READ_DATA;
          oe_next       = 1'b1;
          chrdy_next    = 1'b1;
          state_next    = ST_RD_DRIVE;
        end
      end

      ST_WR_WAIT: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (reg_ack && !wr_reg) begin
          chrdy_next = 1'b1;
          state_next = ST_RELEASE;
        end else if (cnt_reg == CNT_LAST) begin
          err_to_next = 1'b1;
          chrdy_next  = 1'b1;
          state_next  = ST_RELEASE;
        end
      end

      ST_RD_DRIVE: begin
        if (ior_s) begin
          oe_next    = 1'b0;
          state_next = ST_IDLE;
        end
      end

      ST_RELEASE: begin
        if (ior_s && iow_s) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge isa_clk) begin
    if (!isa_reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      addr_hold_reg <= '0;
      data_out_reg  <= '0;
      oe_reg        <= 1'b0;
      chrdy_reg     <= 1'b1;
      reg_addr_reg  <= '0;
      rd_reg        <= 1'b0;
      wr_reg        <= 1'b0;
      wdata_reg     <= '0;
      err_to_reg    <= 1'b0;
      err_pr_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      addr_hold_reg <= addr_latched;
      data_out_reg  <= data_out_next;
      oe_reg        <= oe_next;
      chrdy_reg     <= chrdy_next;
      reg_addr_reg  <= reg_addr_next;
      rd_reg        <= rd_next;
      wr_reg        <= wr_next;
      wdata_reg     <= wdata_next;
      err_to_reg    <= err_to_next;
      err_pr_reg    <= err_pr_next;
    end
  end

  assign isa_data_out = data_out_reg;
  assign isa_data_oe  = oe_reg;
  assign isa_chrdy    = chrdy_reg;
  assign reg_addr     = reg_addr_reg;
  assign reg_rd       = rd_reg;
  assign reg_wr       = wr_reg;
  assign reg_wdata    = wdata_reg;
  assign err_timeout  = err_to_reg;
  assign err_protocol = err_pr_reg;

endmodule
